lut_nco_quad: RTL and testbench



---
 rtl/lut_nco_quad.sv | 210 +++++++++++++++++++++
 tb/tb_lut_nco_quad.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/lut_nco_quad.sv
// Quadrature NCO: phase accumulator feeding a quarter-wave sine ROM with
// symmetry folding. Frequency and phase offset are reprogrammable at run time;
// a new configuration is held in shadow registers and only takes over at a
// phase wrap, while idle, or on a sync clear. That way a period never mixes
// old and new settings.
//
// Config handshake: a transfer happens at a rising edge where cfg_valid and
// cfg_ready are both high. cfg_ready is low while a configuration waits in
// the shadow registers. cfg_valid may be held high; the next transfer is
// taken once the slot frees up.
module lut_nco_quad #(
  parameter int PHASE_W    = 32,
  parameter int LUT_ADDR_W = 8,
  parameter int DATA_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               sync_clr,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [PHASE_W-1:0] freq_word,
  input  logic [PHASE_W-1:0] phase_off,
  output logic [DATA_W-1:0]  sin_out,
  output logic [DATA_W-1:0]  cos_out,
  output logic               out_valid,
  output logic               wrap
);

  localparam int  LUT_N = 1 << LUT_ADDR_W;
  localparam int  LOW_W = PHASE_W - 2 - LUT_ADDR_W;
  localparam real PI    = 3.14159265358979323846;
  localparam real AMP   = real'((1 << (DATA_W - 1)) - 1);

  // Quarter-wave table sampled at bin centres, so that L[~idx] mirrors L[idx]
  // exactly and no entry falls on 0 or on full scale.
  logic [DATA_W-1:0] lut [LUT_N];

  for (genvar k = 0; k < LUT_N; k++) begin : g_lut
    localparam real ANG = 2.0 * PI * (real'(k) + 0.5) / real'(4 * LUT_N);
    localparam int  VAL = $rtoi(AMP * $sin(ANG) + 0.5);
    assign lut[k] = DATA_W'(VAL);
  end

  // Accumulator and configuration state
  logic [PHASE_W-1:0] acc;
  logic [PHASE_W-1:0] freq_act;
  logic [PHASE_W-1:0] off_act;
  logic [PHASE_W-1:0] freq_sh;
  logic [PHASE_W-1:0] off_sh;
  logic               pending;
  logic               wrap_pend;

  logic [PHASE_W:0]   acc_sum;
  logic               carry;
  logic               capture;
  logic               apply;
  logic [PHASE_W-1:0] phase;

  assign acc_sum   = {1'b0, acc} + {1'b0, freq_act};
  assign carry     = acc_sum[PHASE_W];
  assign phase     = acc + off_act;
  assign cfg_ready = ~pending;
  // capture needs an empty slot and apply needs a full one, so they never
  // coincide.
  assign capture   = cfg_valid & ~pending;
  assign apply     = pending & (~en | carry | sync_clr);

  // The truncated low phase bits are intentionally not used.
  if (LOW_W > 0) begin : g_low
    logic unused_low;
    assign unused_low = ^phase[LOW_W-1:0];
  end

  // Phase accumulation and wrap bookkeeping (sync_clr overrides an increment)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      wrap_pend <= 1'b0;
    end else begin
      if (sync_clr) begin
        acc <= '0;
      end else if (en) begin
        acc <= acc_sum[PHASE_W-1:0];
      end
      if (sync_clr) begin
        wrap_pend <= 1'b1;
      end else if (en) begin
        wrap_pend <= carry;
      end
    end
  end

  // Shadow capture on handshake, then transfer to the active registers at a safe point
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      freq_act <= '0;
      off_act  <= '0;
      freq_sh  <= '0;
      off_sh   <= '0;
      pending  <= 1'b0;
    end else if (apply) begin
      freq_act <= freq_sh;
      off_act  <= off_sh;
      pending  <= 1'b0;
    end else if (capture) begin
      freq_sh  <= freq_word;
      off_sh   <= phase_off;
      pending  <= 1'b1;
    end
  end

  // Stage 1: split the offset phase into quadrant and table index
  logic                  s1_valid;
  logic                  s1_wrap;
  logic [1:0]            s1_quad;
  logic [LUT_ADDR_W-1:0] s1_idx;
  logic [LUT_ADDR_W-1:0] s1_idx_inv;

  assign s1_idx_inv = ~s1_idx;

  // Stage 1 register: the phase before this edge's increment is used
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_wrap  <= 1'b0;
      s1_quad  <= '0;
      s1_idx   <= '0;
    end else begin
      s1_valid <= en;
      if (en) begin
        s1_quad <= phase[PHASE_W-1 -: 2];
        s1_idx  <= phase[PHASE_W-3 -: LUT_ADDR_W];
        s1_wrap <= wrap_pend;
      end
    end
  end

  // Stage 2: registered ROM, both the direct and the mirrored entry
  logic              s2_valid;
  logic              s2_wrap;
  logic [1:0]        s2_quad;
  logic [DATA_W-1:0] rom_a;
  logic [DATA_W-1:0] rom_b;

  // Stage 2 register: table read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_wrap  <= 1'b0;
      s2_quad  <= '0;
      rom_a    <= '0;
      rom_b    <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_wrap <= s1_wrap;
        s2_quad <= s1_quad;
        rom_a   <= lut[s1_idx];
        rom_b   <= lut[s1_idx_inv];
      end
    end
  end

  // Quadrant folding; the table amplitude is below full scale, so negation is safe
  logic [DATA_W-1:0] sin_nxt;
  logic [DATA_W-1:0] cos_nxt;

  // Select and sign the table entries per quadrant
  always_comb begin
    sin_nxt = rom_a;
    cos_nxt = rom_b;
    case (s2_quad)
      2'd0: begin
        sin_nxt = rom_a;
        cos_nxt = rom_b;
      end
      2'd1: begin
        sin_nxt = rom_b;
        cos_nxt = -rom_a;
      end
      2'd2: begin
        sin_nxt = -rom_a;
        cos_nxt = -rom_b;
      end
      default: begin
        sin_nxt = -rom_b;
        cos_nxt = rom_a;
      end
    endcase
  end

  // Stage 3: output registers, which hold the last sample while no new one arrives
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      wrap      <= 1'b0;
      sin_out   <= '0;
      cos_out   <= '0;
    end else begin
      out_valid <= s2_valid;
      wrap      <= s2_valid & s2_wrap;
      if (s2_valid) begin
        sin_out <= sin_nxt;
        cos_out <= cos_nxt;
      end
    end
  end

endmodule

// File: tb/tb_lut_nco_quad.sv
// Bench for lut_nco_quad. A reference model computes each expected sample
// directly from the trig functions at the truncated phase. Expected output
// words are queued and compared three edges later.
module tb_lut_nco_quad;

  localparam int  PW  = 32;
  localparam int  LA  = 8;
  localparam int  DW  = 16;
  localparam int  EW  = 2 + 2 * DW;   // {valid, wrap, sin, cos}
  localparam real PI  = 3.14159265358979323846;
  localparam real AMP = 32767.0;

  // Clock and reset
  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          sync_clr;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [PW-1:0] freq_word;
  logic [PW-1:0] phase_off;
  logic [DW-1:0] sin_out;
  logic [DW-1:0] cos_out;
  logic          out_valid;
  logic          wrap;

  always #5 clk = ~clk;

  lut_nco_quad #(.PHASE_W(PW), .LUT_ADDR_W(LA), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .sync_clr  (sync_clr),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .freq_word (freq_word),
    .phase_off (phase_off),
    .sin_out   (sin_out),
    .cos_out   (cos_out),
    .out_valid (out_valid),
    .wrap      (wrap)
  );

  // Scoreboard
  int            n_checks = 0;
  int            n_errors = 0;
  logic [EW-1:0] exp_q[$];

  logic [PW-1:0] m_acc, m_freq, m_off, m_sh_f, m_sh_o;
  bit            m_pend, m_wrap_pend;
  logic [DW-1:0] last_sin, last_cos;

  int exp_s[4] = '{101, 32767, -101, -32767};
  int exp_c[4] = '{32767, -101, -32767, 101};

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int rnd(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    return -$rtoi(-x + 0.5);
  endfunction

  // Ideal sample at the centre of the truncated phase bin
  function automatic logic [EW-1:0] ref_entry(input logic [PW-1:0] p, input bit w);
    int  top;
    real th;
    int  s;
    int  c;
    top = int'(p >> (PW - 2 - LA));
    th  = 2.0 * PI * (real'(top) + 0.5) / real'(1 << (LA + 2));
    s   = rnd(AMP * $sin(th));
    c   = rnd(AMP * $cos(th));
    return {1'b1, w, DW'(s), DW'(c)};
  endfunction

  task automatic model_reset();
    m_acc = '0; m_freq = '0; m_off = '0; m_sh_f = '0; m_sh_o = '0;
    m_pend = 0; m_wrap_pend = 0;
    last_sin = '0; last_cos = '0;
    exp_q.delete();
  endtask

  // Apply one edge's worth of rules to the model, using the currently driven inputs
  task automatic model_edge();
    logic [PW:0] sum;
    bit          carry;
    bit          do_apply;
    sum   = {1'b0, m_acc} + {1'b0, m_freq};
    carry = sum[PW];
    if (en) exp_q.push_back(ref_entry(m_acc + m_off, m_wrap_pend));
    else    exp_q.push_back('0);
    do_apply = m_pend && (!en || carry || sync_clr);
    if (sync_clr)  m_wrap_pend = 1;
    else if (en)   m_wrap_pend = carry;
    if (sync_clr)  m_acc = '0;
    else if (en)   m_acc = sum[PW-1:0];
    if (do_apply) begin
      m_freq = m_sh_f; m_off = m_sh_o; m_pend = 0;
    end else if (cfg_valid && !m_pend) begin
      m_sh_f = freq_word; m_sh_o = phase_off; m_pend = 1;
    end
  endtask

  task automatic check_outputs();
    logic [EW-1:0] e;
    check("cfg_ready", longint'(cfg_ready), longint'(!m_pend));
    e = '0;
    if (exp_q.size() >= 3) e = exp_q.pop_front();
    check("out_valid", longint'(out_valid), longint'(e[EW-1]));
    if (e[EW-1]) begin
      check("sin_out", $signed(sin_out), $signed(e[2*DW-1:DW]));
      check("cos_out", $signed(cos_out), $signed(e[DW-1:0]));
      check("wrap", longint'(wrap), longint'(e[EW-2]));
      last_sin = e[2*DW-1:DW];
      last_cos = e[DW-1:0];
    end else begin
      check("hold_sin", $signed(sin_out), $signed(last_sin));
      check("hold_cos", $signed(cos_out), $signed(last_cos));
      check("wrap_idle", longint'(wrap), 0);
    end
  endtask

  // Driver: inputs are stable from the previous falling edge
  task automatic tick();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; sync_clr = 1'b0; cfg_valid = 1'b0;
    freq_word = '0; phase_off = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_sin", $signed(sin_out), 0);
    check("rst_cos", $signed(cos_out), 0);
    check("rst_valid", longint'(out_valid), 0);
    check("rst_wrap", longint'(wrap), 0);
    check("rst_ready", longint'(cfg_ready), 1);
    rst_n = 1'b1;

    // Configure 2^22 while idle, then start
    cfg_valid = 1'b1; freq_word = 32'h0040_0000; phase_off = '0;
    tick();
    check("hs_taken", longint'(cfg_ready), 0);
    cfg_valid = 1'b0;
    tick();
    check("idle_apply", longint'(cfg_ready), 1);
    en = 1'b1;
    run(3);
    check("first_sin", $signed(sin_out), 101);
    check("first_cos", $signed(cos_out), 32767);
    tick();
    check("second_sin", $signed(sin_out), 302);

    // Quarter-turn step from a cleared accumulator
    en = 1'b0;
    cfg_valid = 1'b1; freq_word = 32'h4000_0000; phase_off = '0;
    tick();
    cfg_valid = 1'b0; sync_clr = 1'b1;
    tick();
    sync_clr = 1'b0; en = 1'b1;
    run(2);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("quarter_sin", $signed(sin_out), exp_s[i % 4]);
      check("quarter_cos", $signed(cos_out), exp_c[i % 4]);
      check("quarter_wrap", longint'(wrap), longint'(i % 4 == 0));
    end

    // Retune to an eighth turn while running; held until the wrap
    cfg_valid = 1'b1; freq_word = 32'h2000_0000;
    tick();
    cfg_valid = 1'b0;
    run(12);

    // sync_clr with a pending config
    cfg_valid = 1'b1; freq_word = 32'h1000_0000; phase_off = '0;
    tick();
    cfg_valid = 1'b0; sync_clr = 1'b1;
    tick();
    check("clr_apply", longint'(cfg_ready), 1);
    sync_clr = 1'b0;
    run(3);
    check("clr_sin", $signed(sin_out), 101);
    check("clr_wrap", longint'(wrap), 1);

    // en gaps
    en = 1'b0; run(3);
    en = 1'b1; tick();
    en = 1'b0; tick();
    en = 1'b1; run(2);
    en = 1'b0; run(4);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      en        = ($urandom_range(9) < 7);
      sync_clr  = ($urandom_range(19) == 0);
      cfg_valid = ($urandom_range(3) == 0);
      freq_word = ($urandom_range(1) == 0) ? $urandom() : ($urandom() >> $urandom_range(8, 2));
      phase_off = $urandom();
      tick();
    end
    sync_clr = 1'b0; cfg_valid = 1'b0;

    // Reset in the middle of a stream
    en = 1'b1;
    run(5);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_sin", $signed(sin_out), 0);
    check("midrst_cos", $signed(cos_out), 0);
    check("midrst_valid", longint'(out_valid), 0);
    check("midrst_wrap", longint'(wrap), 0);
    check("midrst_ready", longint'(cfg_ready), 1);
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    run(5);
    check("post_rst_valid", longint'(out_valid), 0);
    check("post_rst_ready", longint'(cfg_ready), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
